// File: rtl/ysyx_23060203_axi_sram_rd.sv
// ----------------------------------------------------------------------------
// ysyx_23060203_axi_sram_rd
//
// AXI4 read-channel responder backed by a word-addressed SRAM array. It takes
// one AR request at a time. It waits LATENCY idle cycles, then returns a
// FIXED, INCR or WRAP burst of 32-bit beats with matching RID/RRESP/RLAST.
// A separate load port writes the array directly, for simulation and boot
// images.
//
// Parameters
//   DEPTH_W  : array holds 2^DEPTH_W 32-bit words
//   BASE     : byte address of word 0
//   LATENCY  : idle cycles between AR handshake and first RVALID (0..15)
//
// Ports
//   clock, reset          : system clock, synchronous active-low reset
//   arvalid/arready       : AR handshake
//   araddr/arid/arlen/arsize/arburst : AR payload
//   rvalid/rready         : R handshake
//   rdata/rresp/rlast/rid : R payload
//   ld_en/ld_addr/ld_data : array load port (not gated by reset)
// ----------------------------------------------------------------------------
module ysyx_23060203_axi_sram_rd #(
    parameter int          DEPTH_W = 10,
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int          LATENCY = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               arvalid,
    output logic               arready,
    input  logic [31:0]        araddr,
    input  logic [3:0]         arid,
    input  logic [7:0]         arlen,
    input  logic [2:0]         arsize,
    input  logic [1:0]         arburst,
    output logic               rvalid,
    input  logic               rready,
    output logic [31:0]        rdata,
    output logic [1:0]         rresp,
    output logic               rlast,
    output logic [3:0]         rid,
    input  logic               ld_en,
    input  logic [DEPTH_W-1:0] ld_addr,
    input  logic [31:0]        ld_data
);

    localparam logic [3:0]  LAT_INIT  = 4'(LATENCY);
    localparam logic [31:0] MEM_BYTES = 32'd4 << DEPTH_W;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_WAIT  = 3'b010,
        S_BURST = 3'b100
    } state_t;

    state_t state, state_d;

    logic [31:0] addr_q;
    logic [3:0]  id_q;
    logic [7:0]  len_q;
    logic [1:0]  burst_q;
    logic        slverr_q;
    logic [7:0]  beat_cnt;
    logic [3:0]  lat_cnt;

    logic [31:0] mem [0:(1<<DEPTH_W)-1];

    logic        ar_ok_len;
    logic        slverr_d;
    logic [31:0] offset;
    logic        in_range;
    logic [1:0]  beat_resp;
    logic [31:0] wrap_size;
    logic [31:0] wrap_mask;
    logic [31:0] next_addr;
    logic        beat_done;

    // Load port. It writes the array on any edge, whatever the FSM state and
    // the reset level, so an image survives a reset.
    always_ff @(posedge clock) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Request-level errors, decided once at AR acceptance and held for the
    // whole burst. A WRAP length must give a power-of-two beat count.
    always_comb begin
        ar_ok_len = (arlen == 8'd1) || (arlen == 8'd3) ||
                    (arlen == 8'd7) || (arlen == 8'd15);
        slverr_d  = (arsize != 3'b010) ||
                    ((arburst == BURST_WRAP) && !ar_ok_len) ||
                    (araddr[1:0] != 2'b00);
    end

    // Per-beat response and next address. Range is checked on the full byte
    // address before truncating to a word index, so an INCR that runs off the
    // top of the array reports DECERR instead of aliasing back to word 0.
    always_comb begin
        offset    = addr_q - BASE;
        in_range  = (addr_q >= BASE) && (offset < MEM_BYTES);
        beat_resp = slverr_q  ? RESP_SLVERR :
                    !in_range ? RESP_DECERR : RESP_OKAY;

        wrap_size = ({24'd0, len_q} + 32'd1) << 2;
        wrap_mask = wrap_size - 32'd1;

        next_addr = addr_q;
        case (burst_q)
            BURST_INCR:  next_addr = addr_q + 32'd4;
            BURST_WRAP:  next_addr = (addr_q & ~wrap_mask) |
                                     ((addr_q + 32'd4) & wrap_mask);
            BURST_FIXED: next_addr = addr_q;
            default:     next_addr = addr_q;
        endcase
    end

    // FSM state register. Reset is synchronous, so a burst in flight is
    // abandoned at the first reset edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and handshake outputs. Both handshake outputs are also
    // forced low while reset is asserted.
    always_comb begin
        state_d   = state;
        arready   = 1'b0;
        rvalid    = 1'b0;
        beat_done = 1'b0;
        case (state)
            S_IDLE: begin
                arready = 1'b1;
                if (arvalid) begin
                    state_d = (LATENCY == 0) ? S_BURST : S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_cnt <= 4'd1) begin
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                rvalid    = 1'b1;
                beat_done = rready;
                if (rready && (beat_cnt == 8'd0)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!reset) begin
            arready   = 1'b0;
            rvalid    = 1'b0;
            beat_done = 1'b0;
        end
    end

    // Burst bookkeeping. AR fields are captured on acceptance. The latency
    // counter runs down in WAIT. The beat counter and address step only on an
    // accepted beat, so a stalled beat holds all of its outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            addr_q   <= 32'd0;
            id_q     <= 4'd0;
            len_q    <= 8'd0;
            burst_q  <= 2'b00;
            slverr_q <= 1'b0;
            beat_cnt <= 8'd0;
            lat_cnt  <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arvalid) begin
                        addr_q   <= araddr;
                        id_q     <= arid;
                        len_q    <= arlen;
                        burst_q  <= arburst;
                        slverr_q <= slverr_d;
                        beat_cnt <= arlen;
                        lat_cnt  <= LAT_INIT;
                    end
                end
                S_WAIT: begin
                    lat_cnt <= lat_cnt - 4'd1;
                end
                S_BURST: begin
                    if (beat_done && (beat_cnt != 8'd0)) begin
                        beat_cnt <= beat_cnt - 8'd1;
                        addr_q   <= next_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    // R payload. Payload fields read zero when no beat is offered. Error beats
    // carry zero data. The array read is combinational from the registered
    // address, so a load to the presented word shows on the next cycle.
    always_comb begin
        rlast = rvalid && (beat_cnt == 8'd0);
        rid   = rvalid ? id_q : 4'd0;
        rresp = rvalid ? beat_resp : RESP_OKAY;
        rdata = (rvalid && (beat_resp == RESP_OKAY)) ?
                mem[offset[DEPTH_W+1:2]] : 32'd0;
    end

endmodule

// File: tb/tb_ysyx_23060203_axi_sram_rd.sv
// ----------------------------------------------------------------------------
// Testbench for ysyx_23060203_axi_sram_rd. There are two instances. dut_a runs
// with LATENCY=2 and dut_b with LATENCY=0. They share every input except
// arvalid, and each has its own outputs.
// ----------------------------------------------------------------------------
module tb_ysyx_23060203_axi_sram_rd;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        arvalid_a, arvalid_b;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready;
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;

    logic        arready_a, rvalid_a, rlast_a;
    logic [31:0] rdata_a;
    logic [1:0]  rresp_a;
    logic [3:0]  rid_a;
    logic        arready_b, rvalid_b, rlast_b;
    logic [31:0] rdata_b;
    logic [1:0]  rresp_b;
    logic [3:0]  rid_b;

    int          checks = 0;
    int          errors = 0;

    logic [31:0] exp_data [16];
    logic [1:0]  exp_resp [16];
    logic [9:0]  ld_idx;
    logic [31:0] ld_val;

    // Free-running 10 ns clock.
    always #5 clock = ~clock;

    ysyx_23060203_axi_sram_rd #(.DEPTH_W(10), .BASE(BASE), .LATENCY(2)) dut_a (
        .clock(clock), .reset(reset),
        .arvalid(arvalid_a), .arready(arready_a), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid_a), .rready(rready), .rdata(rdata_a), .rresp(rresp_a),
        .rlast(rlast_a), .rid(rid_a),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    ysyx_23060203_axi_sram_rd #(.DEPTH_W(10), .BASE(BASE), .LATENCY(0)) dut_b (
        .clock(clock), .reset(reset),
        .arvalid(arvalid_b), .arready(arready_b), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid_b), .rready(rready), .rdata(rdata_b), .rresp(rresp_b),
        .rlast(rlast_b), .rid(rid_b),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    // Every comparison goes through here. It counts the check and reports
    // any difference.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Writes one array word through the load port.
    task automatic loadWord(input logic [9:0] idx, input logic [31:0] val);
        @(negedge clock);
        ld_en   = 1'b1;
        ld_addr = idx;
        ld_data = val;
        @(negedge clock);
        ld_en   = 1'b0;
    endtask

    // Presents one AR request to the selected instance. The task returns just
    // after the edge that completes the handshake.
    task automatic applyStimulus(input bit sel, input logic [31:0] addr,
                                 input logic [7:0] len, input logic [2:0] size,
                                 input logic [1:0] burst, input logic [3:0] id);
        @(negedge clock);
        checkOutput("arready before AR", sel ? arready_b : arready_a, 1);
        araddr  = addr;
        arlen   = len;
        arsize  = size;
        arburst = burst;
        arid    = id;
        if (sel) arvalid_b = 1'b1;
        else     arvalid_a = 1'b1;
        @(posedge clock);
        #1;
        arvalid_a = 1'b0;
        arvalid_b = 1'b0;
    endtask

    // Collects one burst and checks it against exp_data and exp_resp.
    // Mode 0 holds rready high. Mode 1 drives rready as 1,0,0 repeating.
    // If ld_beat >= 0, the cycle that accepts that beat also writes
    // ld_idx := ld_val through the load port.
    task automatic collectBurst(input bit sel, input int nbeats, input logic [3:0] id,
                                input int lat, input int mode, input int ld_beat,
                                input string tag);
        int          beat    = 0;
        int          waits   = 0;
        int          k       = 0;
        bit          started = 0;
        bit          stalled = 0;
        bit          done    = 0;
        logic        v, l, ar;
        logic [31:0] d, pd;
        logic [1:0]  r, pr;
        logic [3:0]  i, pi;
        logic        pl;
        pd = '0; pr = '0; pi = '0; pl = 1'b0;
        if (mode != 0) rready = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clock);
            ld_en = 1'b0;
            v  = sel ? rvalid_b  : rvalid_a;
            d  = sel ? rdata_b   : rdata_a;
            r  = sel ? rresp_b   : rresp_a;
            l  = sel ? rlast_b   : rlast_a;
            i  = sel ? rid_b     : rid_a;
            ar = sel ? arready_b : arready_a;
            if (!v) begin
                if (!started) waits++;
                else checkOutput({tag, " rvalid gap"}, v, 1);
            end else begin
                if (!started) begin
                    started = 1;
                    checkOutput({tag, " latency"}, waits, lat);
                    checkOutput({tag, " arready in burst"}, ar, 0);
                end
                if (stalled) begin
                    checkOutput({tag, " stall rdata"}, d, pd);
                    checkOutput({tag, " stall rresp"}, r, pr);
                    checkOutput({tag, " stall rlast"}, l, pl);
                    checkOutput({tag, " stall rid"}, i, pi);
                end
                rready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
                k++;
                if (rready) begin
                    if (beat >= nbeats || beat >= 16) begin
                        checkOutput({tag, " extra beat"}, beat, nbeats - 1);
                        done = 1;
                    end else begin
                        checkOutput({tag, " rdata"}, d, exp_data[beat]);
                        checkOutput({tag, " rresp"}, r, exp_resp[beat]);
                        checkOutput({tag, " rid"}, i, id);
                        checkOutput({tag, " rlast"}, l, beat == nbeats - 1);
                        if (beat == ld_beat) begin
                            ld_en   = 1'b1;
                            ld_addr = ld_idx;
                            ld_data = ld_val;
                        end
                        beat++;
                        stalled = 0;
                        if (l) done = 1;
                    end
                end else begin
                    stalled = 1;
                    pd = d; pr = r; pl = l; pi = i;
                end
            end
        end
        checkOutput({tag, " beat count"}, beat, nbeats);
        @(negedge clock);
        ld_en  = 1'b0;
        rready = 1'b1;
        checkOutput({tag, " rvalid after"}, sel ? rvalid_b : rvalid_a, 0);
        checkOutput({tag, " arready after"}, sel ? arready_b : arready_a, 1);
    endtask

    // Directed test sequence.
    initial begin
        int acc;
        reset = 1'b0;
        arvalid_a = 1'b0; arvalid_b = 1'b0;
        araddr = '0; arid = '0; arlen = '0; arsize = 3'b010; arburst = 2'b01;
        rready = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        ld_idx = '0; ld_val = '0;

        repeat (3) @(negedge clock);
        checkOutput("reset arready", arready_a, 0);
        checkOutput("reset rvalid", rvalid_a, 0);
        checkOutput("reset rlast", rlast_a, 0);
        checkOutput("reset rresp", rresp_a, 0);
        checkOutput("reset rid", rid_a, 0);
        checkOutput("reset rdata", rdata_a, 0);
        checkOutput("reset rvalid b", rvalid_b, 0);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("post-reset arready", arready_a, 1);
        checkOutput("post-reset arready b", arready_b, 1);

        for (int n = 0; n < 16; n++) loadWord(10'(n), 32'h1000 + n);
        loadWord(10'd1022, 32'hA000_03FE);
        loadWord(10'd1023, 32'hA000_03FF);

        // INCR with 4 beats from word 0.
        for (int n = 0; n < 4; n++) begin exp_data[n] = 32'h1000 + n; exp_resp[n] = 2'b00; end
        applyStimulus(0, BASE, 8'd3, 3'b010, 2'b01, 4'h5);
        collectBurst(0, 4, 4'h5, 2, 0, -1, "incr4");

        // WRAP with 16 beats. It starts at word 5 and wraps to word 0.
        for (int n = 0; n < 16; n++) begin
            exp_data[n] = 32'h1000 + ((5 + n) % 16);
            exp_resp[n] = 2'b00;
        end
        applyStimulus(0, BASE + 32'h14, 8'd15, 3'b010, 2'b10, 4'h3);
        collectBurst(0, 16, 4'h3, 2, 0, -1, "wrap16");

        // INCR with 8 beats from word 8, with rready stalls.
        for (int n = 0; n < 8; n++) begin exp_data[n] = 32'h1008 + n; exp_resp[n] = 2'b00; end
        applyStimulus(0, BASE + 32'h20, 8'd7, 3'b010, 2'b01, 4'h9);
        collectBurst(0, 8, 4'h9, 2, 1, -1, "stall8");

        // Illegal arsize gives SLVERR on both beats.
        for (int n = 0; n < 2; n++) begin exp_data[n] = 32'h0; exp_resp[n] = 2'b10; end
        applyStimulus(0, BASE, 8'd1, 3'b000, 2'b01, 4'h1);
        collectBurst(0, 2, 4'h1, 2, 0, -1, "badsize");

        // Address below BASE gives DECERR.
        exp_data[0] = 32'h0; exp_resp[0] = 2'b11;
        applyStimulus(0, 32'h7FFF_FFF0, 8'd0, 3'b010, 2'b01, 4'h2);
        collectBurst(0, 1, 4'h2, 2, 0, -1, "decerr");

        // WRAP with a 3-beat length gives SLVERR on all beats.
        for (int n = 0; n < 3; n++) begin exp_data[n] = 32'h0; exp_resp[n] = 2'b10; end
        applyStimulus(0, BASE, 8'd2, 3'b010, 2'b10, 4'h4);
        collectBurst(0, 3, 4'h4, 2, 0, -1, "badwrap");

        // Misaligned start address gives SLVERR.
        exp_data[0] = 32'h0; exp_resp[0] = 2'b10;
        applyStimulus(0, BASE + 32'h2, 8'd0, 3'b010, 2'b01, 4'h6);
        collectBurst(0, 1, 4'h6, 2, 0, -1, "misalign");

        // INCR that runs past the top of the array.
        exp_data[0] = 32'hA000_03FE; exp_resp[0] = 2'b00;
        exp_data[1] = 32'hA000_03FF; exp_resp[1] = 2'b00;
        exp_data[2] = 32'h0;         exp_resp[2] = 2'b11;
        exp_data[3] = 32'h0;         exp_resp[3] = 2'b11;
        applyStimulus(0, BASE + 32'hFF8, 8'd3, 3'b010, 2'b01, 4'h7);
        collectBurst(0, 4, 4'h7, 2, 0, -1, "topcross");

        // Reset while beat 2 of an 8-beat INCR is on the bus.
        rready = 1'b1;
        applyStimulus(0, BASE, 8'd7, 3'b010, 2'b01, 4'h8);
        acc = 0;
        for (int c = 0; c < 50 && acc < 2; c++) begin
            @(negedge clock);
            if (rvalid_a) acc++;
        end
        @(negedge clock);
        checkOutput("midrst beat2 rvalid", rvalid_a, 1);
        checkOutput("midrst beat2 rdata", rdata_a, 32'h1002);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("midrst rvalid in reset", rvalid_a, 0);
        checkOutput("midrst arready in reset", arready_a, 0);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("midrst rvalid after", rvalid_a, 0);
        checkOutput("midrst arready after", arready_a, 1);

        // Array contents survive the reset.
        for (int n = 0; n < 4; n++) begin exp_data[n] = 32'h1000 + n; exp_resp[n] = 2'b00; end
        applyStimulus(0, BASE, 8'd3, 3'b010, 2'b01, 4'hC);
        collectBurst(0, 4, 4'hC, 2, 0, -1, "afterrst");

        // LATENCY=0 instance: FIXED burst at word 7. The word is rewritten
        // during beat 2.
        exp_data[0] = 32'h1007;      exp_resp[0] = 2'b00;
        exp_data[1] = 32'h1007;      exp_resp[1] = 2'b00;
        exp_data[2] = 32'hDEAD_BEEF; exp_resp[2] = 2'b00;
        exp_data[3] = 32'hDEAD_BEEF; exp_resp[3] = 2'b00;
        ld_idx = 10'd7;
        ld_val = 32'hDEAD_BEEF;
        applyStimulus(1, BASE + 32'h1C, 8'd3, 3'b010, 2'b00, 4'hA);
        collectBurst(1, 4, 4'hA, 0, 0, 1, "fixedld");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
